// File: rtl/serial_mac_pkg.sv
// serial_mac_pkg: shared state encoding and width helpers for the bit-serial MAC
package serial_mac_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

   // Exact signed product width of an na x nb multiply.
   function automatic int prod_w(input int na, input int nb);
      return na + nb;
   endfunction

   // Product-plus-result sum width: one guard bit over the wider operand.
   function automatic int sum_w(input int na, input int nb, input int nr);
      return ((na + nb > nr) ? na + nb : nr) + 1;
   endfunction

endpackage

// File: rtl/serial_mac_sat_trunc.sv
// sat_trunc: narrow a signed value to OW bits by clamping (SATURATE!=0) or wrapping
//   din  in   IW  signed value to narrow (IW > OW)
//   dout out  OW  clamped or low-OW-bit value
//   ovf  out  1   din does not fit in OW signed bits
module sat_trunc #(
   parameter int IW       = 17,
   parameter int OW       = 16,
   parameter int SATURATE = 1
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout,
   output logic                 ovf
);

   logic [IW-OW:0] top;

   // The value fits exactly when every bit from the result sign bit upward agrees.
   assign top  = din[IW-1:OW-1];
   assign ovf  = !((&top) || !(|top));
   assign dout = (ovf && SATURATE != 0) ? (din[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                                        : din[OW-1:0];

endmodule

// File: rtl/serial_mac.sv
// serial_mac: bit-serial signed multiply-accumulate with saturating/wrapping result
//   clk, reset       clock and asynchronous active-high reset
//   a, b             signed operands, latched on an accepted start
//   start, acc_en    request and accumulate-onto-result flag (sampled with start)
//   clear            zero result/overflow while idle; forces accumulate base to 0 with start
//   busy, data_ready operation in progress / result valid until the next accepted start
//   result, overflow signed result and narrowing flag of the last operation
module serial_mac
   import serial_mac_pkg::*;
#(
   parameter int N_BITS_A      = 8,
   parameter int N_BITS_B      = 8,
   parameter int N_BITS_RESULT = 16,
   parameter int SATURATE      = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic signed [N_BITS_A-1:0]      a,
   input  logic signed [N_BITS_B-1:0]      b,
   input  logic                            start,
   input  logic                            acc_en,
   input  logic                            clear,
   output logic                            busy,
   output logic                            data_ready,
   output logic signed [N_BITS_RESULT-1:0] result,
   output logic                            overflow
);

   localparam int PW = prod_w(N_BITS_A, N_BITS_B);
   localparam int SW = sum_w(N_BITS_A, N_BITS_B, N_BITS_RESULT);
   localparam int CW = $clog2(N_BITS_B) + 1;
   localparam logic [CW-1:0] LAST = CW'(N_BITS_B - 1);

   state_t                           state, state_nxt;
   logic [CW-1:0]                    cnt;
   logic signed [N_BITS_A-1:0]       a_q;
   logic [N_BITS_B-1:0]              b_q;
   logic                             use_acc, accept, last, b_bit, sat_ovf;
   logic signed [PW-1:0]             prod, a_ext, term;
   logic signed [SW-1:0]             sum, sum_q, p_ext, r_ext;
   logic signed [N_BITS_RESULT-1:0]  sat_res;

   assign busy       = (state == RUN) || (state == FINAL);
   assign data_ready = state == DONE;
   assign accept     = start && !busy;
   assign last       = cnt == LAST;
   assign b_bit      = |(b_q & (N_BITS_B'(1) << cnt));
   assign a_ext      = {{N_BITS_B{a_q[N_BITS_A-1]}}, a_q};
   assign term       = a_ext << cnt;
   assign p_ext      = {{(SW-PW){prod[PW-1]}}, prod};
   assign r_ext      = {{(SW-N_BITS_RESULT){result[N_BITS_RESULT-1]}}, result};
   assign sum        = p_ext + (use_acc ? r_ext : '0);

   always_comb begin
      state_nxt = accept                      ? RUN   :
                  (state == RUN && last)      ? FINAL :
                  (state == FINAL && cnt[0])  ? DONE  : state;
   end

   // FINAL spends two cycles: the wide sum is registered first so the adder and the
   // saturation compare never sit in one combinational path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         use_acc  <= 1'b0;
         prod     <= '0;
         sum_q    <= '0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            use_acc <= acc_en && !clear;
            prod    <= '0;
            cnt     <= '0;
         end else if (state == RUN) begin
            cnt <= last ? '0 : cnt + 1'b1;
            // The top multiplier bit carries negative weight in two's complement.
            if (b_bit) prod <= last ? prod - term : prod + term;
         end else if (state == FINAL) begin
            cnt <= cnt + 1'b1;
            if (!cnt[0]) sum_q <= sum;
            else begin
               result   <= sat_res;
               overflow <= sat_ovf;
            end
         end else if (clear) begin
            result   <= '0;
            overflow <= 1'b0;
         end
      end
   end

   sat_trunc #(
      .IW(SW),
      .OW(N_BITS_RESULT),
      .SATURATE(SATURATE)
   ) u_sat (
      .din(sum_q),
      .dout(sat_res),
      .ovf(sat_ovf)
   );

endmodule
